// File: rtl/timer_event_counter.sv
// Timer/event counter: counts unit_pulse ticks while running, wraps in
// free-run, auto-reload or one-shot fashion, and raises a sticky interrupt.
module timer_event_counter #(
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   unit_pulse,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic                   reload_update,
  input  logic [TIMER_WIDTH-1:0] reload_value,
  input  logic                   irq_clear,
  output logic [TIMER_WIDTH-1:0] count,
  output logic                   overflow,
  output logic                   irq_flag,
  output logic                   running
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] ALL_ONES = '1;

  state_t                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] count_q, count_d;
  logic [TIMER_WIDTH-1:0] reload_q, reload_d;
  logic                   overflow_q, overflow_d;
  logic                   irq_q, irq_d;
  logic                   running_q, running_d;

  logic tickTaken;
  logic wrapEvent;

  // A tick only counts in RUN, and a stop or reload in the same cycle swallows it.
  always_comb begin
    tickTaken = (state_q == RUN) && unit_pulse && !stop && !reload_update;
    wrapEvent = tickTaken && (count_q == ALL_ONES);
  end

  // Next-state, count, reload and flag computation; mode is looked at live.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    overflow_d = 1'b0;
    irq_d      = irq_q;

    if (reload_update) begin
      reload_d = reload_value;
      count_d  = reload_value;
    end else if (tickTaken) begin
      if (wrapEvent) begin
        overflow_d = 1'b1;
        if (mode == 2'd0) begin
          count_d = '0;
        end else begin
          count_d = reload_q;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if (stop) begin
      state_d = IDLE;
    end else if (start && (state_q != RUN)) begin
      state_d = RUN;
    end else if (wrapEvent && (mode == 2'd2)) begin
      state_d = EXPIRED;
    end

    if (wrapEvent) begin
      irq_d = 1'b1;
    end else if (irq_clear) begin
      irq_d = 1'b0;
    end

    running_d = (state_d == RUN);
  end

  // State and output registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
      running_q  <= running_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign irq_flag = irq_q;
  assign running  = running_q;

endmodule
